// File: rtl/udp_tx_arbiter.sv
// Round-robin packet arbiter that merges NUM_PORTS AXI-Stream requesters onto the
// single UDP TX user input. Each grant is held for one whole packet, up to its tlast handshake.
module udp_tx_arbiter #(
  parameter int DATA_WIDTH    = 512,
  parameter int CONN_ID_WIDTH = 18,
  parameter int NUM_PORTS     = 4
) (
  input  logic                                 tx_axis_aclk,
  input  logic                                 tx_axis_rst,
  input  logic                                 arb_enable,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]                 s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                 s_axis_tlast,
  input  logic [NUM_PORTS*CONN_ID_WIDTH-1:0]   s_axis_connection_id,
  output logic [NUM_PORTS-1:0]                 s_axis_tready,
  output logic [DATA_WIDTH-1:0]                udp_tx_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]              udp_tx_axis_tkeep,
  output logic                                 udp_tx_axis_tvalid,
  output logic                                 udp_tx_axis_tlast,
  output logic [CONN_ID_WIDTH-1:0]             udp_tx_axis_connection_id,
  input  logic                                 udp_tx_axis_tready,
  output logic [NUM_PORTS-1:0]                 grant_onehot,
  output logic                                 busy,
  output logic [NUM_PORTS*32-1:0]              pkt_count
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int KEEP_W = DATA_WIDTH / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        last_grant;

  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;

  logic [DATA_WIDTH-1:0]   g_data;
  logic [KEEP_W-1:0]       g_keep;
  logic                    g_valid;
  logic                    g_last;

  // Walk candidates from farthest to nearest so the nearest valid port after
  // last_grant is the final (winning) assignment.
  always_comb begin : rr_pick
    int               cand;
    logic [IDX_W-1:0] ci;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    ci         = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % NUM_PORTS;
      ci   = cand[IDX_W-1:0];
      if (s_axis_tvalid[ci]) begin
        pick_valid = 1'b1;
        pick_idx   = ci;
      end
    end
  end

  assign g_data  = s_axis_tdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign g_keep  = s_axis_tkeep[int'(grant_idx)*KEEP_W +: KEEP_W];
  assign g_valid = (state == BUSY) && s_axis_tvalid[grant_idx];
  assign g_last  = s_axis_tlast[grant_idx];

  // Data and keep are forced to zero on idle cycles so downstream never sees stale bytes.
  assign udp_tx_axis_tvalid = g_valid;
  assign udp_tx_axis_tdata  = g_valid ? g_data : '0;
  assign udp_tx_axis_tkeep  = g_valid ? g_keep : '0;
  assign udp_tx_axis_tlast  = g_valid & g_last;

  // grant_onehot is zero outside BUSY, so it doubles as the ready steering mask.
  assign s_axis_tready = grant_onehot & {NUM_PORTS{udp_tx_axis_tready}};

  always_ff @(posedge tx_axis_aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (tx_axis_rst) begin
      state                     <= IDLE;
      busy                      <= 1'b0;
      grant_onehot              <= '0;
      grant_idx                 <= '0;
      last_grant                <= IDX_W'(NUM_PORTS - 1);
      udp_tx_axis_connection_id <= '0;
      pkt_count                 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_enable && pick_valid) begin
            state                     <= BUSY;
            busy                      <= 1'b1;
            grant_idx                 <= pick_idx;
            grant_onehot              <= NUM_PORTS'(1) << pick_idx;
            udp_tx_axis_connection_id <=
              s_axis_connection_id[int'(pick_idx)*CONN_ID_WIDTH +: CONN_ID_WIDTH];
          end
        end
        BUSY: begin
          // Only the tlast handshake ends a packet; arb_enable and tvalid gaps do not.
          if (g_valid && udp_tx_axis_tready && g_last) begin
            state        <= IDLE;
            busy         <= 1'b0;
            grant_onehot <= '0;
            last_grant   <= grant_idx;
            pkt_count[int'(grant_idx)*32 +: 32] <= pkt_count[int'(grant_idx)*32 +: 32] + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning the AXIS data width in bits on all ports.
REQ-002 SHALL have parameter CONN_ID_WIDTH, default 18, meaning the connection ID width.
REQ-003 SHALL have parameter NUM_PORTS, default 4, meaning the number of requester streams (legal range 2-16).
REQ-004 SHALL have port tx_axis_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port tx_axis_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port arb_enable, input, 1 bit: high permits new grants.
REQ-007 SHALL have port s_axis_tdata, input, NUM_PORTS*DATA_WIDTH: requester data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port s_axis_tkeep, input, NUM_PORTS*DATA_WIDTH/8: requester byte enables.
REQ-009 SHALL have ports s_axis_tvalid and s_axis_tlast, input, NUM_PORTS each: per-requester valid and last.
REQ-010 SHALL have port s_axis_connection_id, input, NUM_PORTS*CONN_ID_WIDTH: per-requester connection ID, sampled on a requester's first beat.
REQ-011 SHALL have port s_axis_tready, output, NUM_PORTS: per-requester ready.
REQ-012 SHALL have ports udp_tx_axis_tdata (DATA_WIDTH), udp_tx_axis_tkeep (DATA_WIDTH/8), udp_tx_axis_tvalid (1), udp_tx_axis_tlast (1) and udp_tx_axis_connection_id (CONN_ID_WIDTH), all outputs, driving the Ethernet TX user input.
REQ-013 SHALL have port udp_tx_axis_tready, input, 1 bit: backpressure from the Ethernet TX block.
REQ-014 SHALL have port grant_onehot, output, NUM_PORTS: currently granted requester, all zeros when idle.
REQ-015 SHALL have port busy, output, 1 bit: high in state BUSY.
REQ-016 SHALL have port pkt_count, output, NUM_PORTS*32: completed-packet counter per requester.

Function
REQ-017 SHALL implement FSM states IDLE and BUSY.
REQ-018 In IDLE, when arb_enable=1 and any s_axis_tvalid is high, SHALL select the first valid requester searching round-robin from last_grant+1 (modulo NUM_PORTS), register it into grant_onehot, and enter BUSY on the next edge.
REQ-019 Arbitration latency: SHALL give one cycle from a requester's tvalid in IDLE to its first possible transfer; no output beat is presented in IDLE.
REQ-020 In BUSY, SHALL drive udp_tx_axis_tdata, tkeep, tlast and tvalid combinationally from the granted requester only.
REQ-021 In BUSY, s_axis_tready[g] SHALL equal udp_tx_axis_tready; all other s_axis_tready bits SHALL be 0, and all bits SHALL be 0 in IDLE.
REQ-022 udp_tx_axis_connection_id SHALL be the granted requester's ID, registered at grant time and held constant for the whole packet.
REQ-023 On a handshake (tvalid & tready) with tlast=1, SHALL set last_grant to g, increment pkt_count[g] by 1 (32-bit wrap, 0xFFFFFFFF->0), clear grant_onehot, and return to IDLE.
REQ-024 SHALL never switch grant mid-packet; a packet is atomic from grant until its tlast handshake.
REQ-025 arb_enable deasserted in BUSY SHALL NOT abort the packet; only new grants are blocked.
REQ-026 A granted requester dropping tvalid mid-packet SHALL hold the grant with udp_tx_axis_tvalid=0 (no timeout).
REQ-027 A single-beat packet (tlast on first beat) SHALL complete in BUSY and return to IDLE, giving 2 cycles minimum per packet.
REQ-028 With all NUM_PORTS requesters continuously valid, grants SHALL rotate 0,1,2,...,NUM_PORTS-1,0 with no requester granted twice before every other valid requester has been granted once.
REQ-029 udp_tx_axis_tdata and tkeep SHALL be 0 whenever udp_tx_axis_tvalid=0.

Reset
REQ-030 While tx_axis_rst=1 at a clock edge, SHALL set state=IDLE, grant_onehot=0, last_grant=NUM_PORTS-1 (so port 0 wins first), pkt_count all 0, busy=0, udp_tx_axis_tvalid=0, udp_tx_axis_tlast=0, udp_tx_axis_connection_id=0, and s_axis_tready all 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet immediately, with no pkt_count increment; the requester restarts the packet after reset.

Verification
REQ-032 Bench SHALL cover: after reset, ports 0 and 2 valid simultaneously with 3-beat packets -> port 0 granted first (grant_onehot=0001), then port 2 (0100), pkt_count[0]=pkt_count[2]=1.
REQ-033 Bench SHALL cover: all 4 ports valid continuously for 8 packets -> grant order 0,1,2,3,0,1,2,3, each pkt_count=2.
REQ-034 Bench SHALL cover: udp_tx_axis_tready low 5 cycles mid-packet on port 1 -> data held stable, s_axis_tready[1]=0, no grant change, connection_id constant.
REQ-035 Bench SHALL cover: arb_enable dropped on beat 2 of 4 -> packet completes with 4 beats, then stays IDLE with grant_onehot=0 until arb_enable=1.
REQ-036 Bench SHALL cover: pkt_count[3] preloaded to 0xFFFFFFFF by forcing, then one packet -> 0x00000000.
REQ-037 Bench SHALL cover: reset pulse on beat 2 of 5 -> next cycle busy=0, all tready=0, pkt_count unchanged at 0.
